// File: rtl/qpsk_pkg.sv
// Shared QPSK definitions: transmitter state encoding, default constellation
// parameters and the sign-bit to amplitude mapping.
package qpsk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MID  = 2'd1,
        ON   = 2'd2
    } tx_state_t;

    localparam int DEF_AMP            = 256;
    localparam int DEF_CLK_PER_SAMPLE = 9;

    // Sign bit 0 maps to +amp and 1 maps to -amp; the decision slicer uses the same rule.
    function automatic int sym_map(input logic sign, input int amp);
        return sign ? -amp : amp;
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Modulo-N sample counter with enable and synchronous clear; tick marks the last count.
module sample_tick_gen
    import qpsk_pkg::*;
#(
    parameter int N = DEF_CLK_PER_SAMPLE
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [CW-1:0] count;

    assign tick = en && (count == CW'(N - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/qpsk_sym_tx.sv
// QPSK test-symbol transmitter: two I/Q samples per accepted symbol, a mid-transition
// average of the previous and current symbol followed by the on-time symbol value.
module qpsk_sym_tx
    import qpsk_pkg::*;
#(
    parameter int width          = 15,
    parameter int AMP            = DEF_AMP,
    parameter int CLK_PER_SAMPLE = DEF_CLK_PER_SAMPLE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [1:0]         sym_data,
    input  logic               sym_valid,
    output logic               sym_ready,
    output logic signed [width:0] I_interp_tx,
    output logic signed [width:0] Q_interp_tx,
    output logic               tx_en_I,
    output logic               tx_en_Q,
    output logic               tx_on_time,
    output logic               underrun
);

    localparam int W = width + 1;

    tx_state_t state;
    logic      tick;

    logic signed [width:0]   prev_i, prev_q, cur_i, cur_q;
    logic signed [width:0]   new_i, new_q;
    logic signed [width+1:0] sum_i, sum_q;

    sample_tick_gen #(.N(CLK_PER_SAMPLE)) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (state != IDLE),
        .clr   (state == IDLE),
        .tick  (tick)
    );

    assign sym_ready = (state == MID) && tick;

    // A missing symbol is sent as the zero point so the stream keeps its cadence.
    always_comb begin
        new_i = '0;
        new_q = '0;
        if (sym_valid) begin
            new_i = W'(sym_map(sym_data[1], AMP));
            new_q = W'(sym_map(sym_data[0], AMP));
        end
    end

    // One guard bit keeps prev + cur from overflowing before the halving shift.
    assign sum_i = {prev_i[width], prev_i} + {new_i[width], new_i};
    assign sum_q = {prev_q[width], prev_q} + {new_q[width], new_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            prev_i      <= '0;
            prev_q      <= '0;
            cur_i       <= '0;
            cur_q       <= '0;
            I_interp_tx <= '0;
            Q_interp_tx <= '0;
            tx_en_I     <= 1'b0;
            tx_en_Q     <= 1'b0;
            tx_on_time  <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            tx_en_I    <= 1'b0;
            tx_en_Q    <= 1'b0;
            tx_on_time <= 1'b0;
            underrun   <= 1'b0;
            case (state)
                IDLE: begin
                    if (run) begin
                        state <= MID;
                    end
                end
                MID: begin
                    if (tick) begin
                        cur_i       <= new_i;
                        cur_q       <= new_q;
                        I_interp_tx <= W'(sum_i >>> 1);
                        Q_interp_tx <= W'(sum_q >>> 1);
                        tx_en_I     <= 1'b1;
                        tx_en_Q     <= 1'b1;
                        underrun    <= !sym_valid;
                        state       <= ON;
                    end
                end
                ON: begin
                    if (tick) begin
                        I_interp_tx <= cur_i;
                        Q_interp_tx <= cur_q;
                        prev_i      <= cur_i;
                        prev_q      <= cur_q;
                        tx_en_I     <= 1'b1;
                        tx_en_Q     <= 1'b1;
                        tx_on_time  <= 1'b1;
                        state       <= run ? MID : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qpsk_sym_tx.sv
// Self-checking bench for qpsk_sym_tx: directed and random symbol phases compared
// against a symbol-level model of the expected sample stream.
module tb_qpsk_sym_tx;

    localparam int CPS  = 9;
    localparam int AMPV = 256;

    typedef struct {
        int i;
        int q;
        bit on;
        int cyc;
    } samp_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               run;
    logic [1:0]         sym_data;
    logic               sym_valid;
    logic               sym_ready;
    logic signed [15:0] I_interp_tx;
    logic signed [15:0] Q_interp_tx;
    logic               tx_en_I;
    logic               tx_en_Q;
    logic               tx_on_time;
    logic               underrun;

    qpsk_sym_tx #(.width(15), .AMP(AMPV), .CLK_PER_SAMPLE(CPS)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .sym_data    (sym_data),
        .sym_valid   (sym_valid),
        .sym_ready   (sym_ready),
        .I_interp_tx (I_interp_tx),
        .Q_interp_tx (Q_interp_tx),
        .tx_en_I     (tx_en_I),
        .tx_en_Q     (tx_en_Q),
        .tx_on_time  (tx_on_time),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation side: record every strobe and count protocol violations.
    samp_t obs_q[$];
    int    n_pair_bad = 0, n_ontime_bad = 0, n_ready_bad = 0, n_under_bad = 0, n_under = 0;
    bit    ready_prev = 1'b0, valid_prev = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            ready_prev = 1'b0;
            valid_prev = 1'b0;
        end else begin
            if (tx_en_I !== tx_en_Q) n_pair_bad++;
            if (!tx_en_I && tx_on_time) n_ontime_bad++;
            if ((tx_en_I && !tx_on_time) !== ready_prev) n_ready_bad++;
            if (underrun !== (ready_prev && !valid_prev)) n_under_bad++;
            if (underrun) n_under++;
            if (tx_en_I) obs_q.push_back('{int'(I_interp_tx), int'(Q_interp_tx), tx_on_time, cyc});
            ready_prev = sym_ready;
            valid_prev = sym_valid;
        end
    end

    int    n_cmp = 0, n_err = 0;
    samp_t exp_q[$];
    int    plan[$];
    int    m_prev_i = 0, m_prev_q = 0;
    int    rd_idx = 0, start_cyc = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ":I"}, int'(I_interp_tx), 0);
        check({tag, ":Q"}, int'(Q_interp_tx), 0);
        check({tag, ":en_I"}, int'(tx_en_I), 0);
        check({tag, ":en_Q"}, int'(tx_en_Q), 0);
        check({tag, ":on_time"}, int'(tx_on_time), 0);
        check({tag, ":underrun"}, int'(underrun), 0);
        check({tag, ":ready"}, int'(sym_ready), 0);
    endtask

    // Symbol-level model: mid = (prev + cur) / 2 then on = cur; a missing symbol is (0,0).
    task automatic model_push(input int d);
        int ci, cq;
        ci = (d < 0) ? 0 : (((d & 2) != 0) ? -AMPV : AMPV);
        cq = (d < 0) ? 0 : (((d & 1) != 0) ? -AMPV : AMPV);
        exp_q.push_back('{(m_prev_i + ci) / 2, (m_prev_q + cq) / 2, 1'b0, 0});
        exp_q.push_back('{ci, cq, 1'b1, 0});
        m_prev_i = ci;
        m_prev_q = cq;
    endtask

    // Offer one symbol (d >= 0) or nothing (d < 0) at the next MID tick.
    task automatic slot(input int d);
        int w;
        if (d >= 0) begin
            sym_data  = 2'(d);
            sym_valid = 1'b1;
        end else begin
            sym_valid = 1'b0;
        end
        w = 0;
        @(negedge clk);
        while (!sym_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("ready_seen", int'(sym_ready), 1);
        @(posedge clk);
        #1;
        sym_valid = 1'b0;
    endtask

    task automatic run_phase(input string name, input bit loop_check);
        int    u0, n_und_exp, n0, prev_cyc, lm_i, lm_q, po_i, po_q;
        bit    first, have_on;
        samp_t e, o;
        rd_idx = obs_q.size();
        exp_q.delete();
        u0 = n_under;
        n_und_exp = 0;
        @(posedge clk);
        #1;
        run = 1'b1;
        start_cyc = cyc;
        foreach (plan[k]) begin
            model_push(plan[k]);
            if (plan[k] < 0) n_und_exp++;
            slot(plan[k]);
        end
        run = 1'b0;
        for (int w = 0; w < 4 * CPS && obs_q.size() < rd_idx + exp_q.size(); w++) @(negedge clk);
        check({name, ":strobe_count"}, obs_q.size() - rd_idx, exp_q.size());
        first = 1'b1;
        have_on = 1'b0;
        prev_cyc = 0;
        lm_i = 0; lm_q = 0; po_i = 0; po_q = 0;
        while (exp_q.size() > 0 && rd_idx < obs_q.size()) begin
            e = exp_q.pop_front();
            o = obs_q[rd_idx];
            rd_idx++;
            check({name, ":I"}, o.i, e.i);
            check({name, ":Q"}, o.q, e.q);
            check({name, ":on_time"}, int'(o.on), int'(e.on));
            if (first) check({name, ":start_latency"}, o.cyc - start_cyc, CPS + 1);
            else       check({name, ":spacing"}, o.cyc - prev_cyc, CPS);
            first = 1'b0;
            prev_cyc = o.cyc;
            if (loop_check) begin
                if (!o.on) begin
                    lm_i = o.i;
                    lm_q = o.q;
                end else begin
                    // Gardner-style error: mid * (previous on-time - current on-time).
                    if (have_on) begin
                        check({name, ":ted_er_I"}, lm_i * (po_i - o.i), 0);
                        check({name, ":ted_er_Q"}, lm_q * (po_q - o.q), 0);
                    end
                    have_on = 1'b1;
                    po_i = o.i;
                    po_q = o.q;
                end
            end
        end
        exp_q.delete();
        n0 = obs_q.size();
        repeat (3 * CPS) @(negedge clk);
        check({name, ":idle_no_strobe"}, obs_q.size(), n0);
        check({name, ":hold_I"}, int'(I_interp_tx), m_prev_i);
        check({name, ":hold_Q"}, int'(Q_interp_tx), m_prev_q);
        check({name, ":underruns"}, n_under - u0, n_und_exp);
        check({name, ":en_pair_bad"}, n_pair_bad, 0);
        check({name, ":on_time_bad"}, n_ontime_bad, 0);
        check({name, ":ready_bad"}, n_ready_bad, 0);
        check({name, ":underrun_bad"}, n_under_bad, 0);
    endtask

    initial begin
        int n0;
        reset = 1'b1;
        run = 1'b0;
        sym_valid = 1'b0;
        sym_data = 2'b00;
        #2;
        check_zero("por");
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("por_idle_no_strobe", obs_q.size(), 0);

        plan = '{0, 0};
        run_phase("startup", 1'b0);
        plan = '{0, 3, 2};
        run_phase("transitions", 1'b0);
        plan = '{0, -1, 1};
        run_phase("underrun", 1'b0);

        plan.delete();
        for (int k = 0; k < 16; k++) begin
            if ($urandom_range(0, 4) == 0) plan.push_back(-1);
            else plan.push_back(int'($urandom_range(0, 3)));
        end
        run_phase("random", 1'b0);

        // Asynchronous reset between clock edges while a symbol is in flight.
        @(posedge clk);
        #1;
        run = 1'b1;
        slot(3);
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_zero("async_rst");
        run = 1'b0;
        sym_valid = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b0;
        m_prev_i = 0;
        m_prev_q = 0;
        n0 = obs_q.size();
        repeat (2 * CPS + 2) @(negedge clk);
        check("rst_no_strobe", obs_q.size(), n0);
        check("rst_hold_I", int'(I_interp_tx), 0);

        plan = '{0, 0};
        run_phase("restart", 1'b0);
        plan = '{3, 0, 3, 0, 3, 0, 3, 0, 3, 0};
        run_phase("loopback", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed running, expected done");
        $fatal(1, "watchdog");
    end

endmodule
